// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 16-bit MIPS pipeline: load-use bubble insertion,
// branch squash, WB->ID same-cycle bypass and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned REG_AW   = 4,
    parameter int unsigned ALU_OP_W = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs,
    input  logic [REG_AW-1:0]   id_rt,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_uses_rt,
    input  logic [DATA_W-1:0]   id_rs_data,
    input  logic [DATA_W-1:0]   id_rt_data,
    input  logic [DATA_W-1:0]   id_imm,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_alu_src,
    input  logic                id_mem_read,
    input  logic                id_mem_write,
    input  logic                id_reg_write,
    input  logic                id_mem_to_reg,
    input  logic                wb_reg_write,
    input  logic [REG_AW-1:0]   wb_rd,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                flush_ex,
    output logic                stall,
    output logic                ex_valid,
    output logic [REG_AW-1:0]   ex_rs,
    output logic [REG_AW-1:0]   ex_rt,
    output logic [REG_AW-1:0]   ex_rd,
    output logic [DATA_W-1:0]   ex_rs_data,
    output logic [DATA_W-1:0]   ex_rt_data,
    output logic [DATA_W-1:0]   ex_imm,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_alu_src,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_reg_write,
    output logic                ex_mem_to_reg,
    output logic [CNT_W-1:0]    stall_count,
    output logic [CNT_W-1:0]    flush_count
);

    typedef struct packed {
        logic                valid;
        logic [REG_AW-1:0]   rs;
        logic [REG_AW-1:0]   rt;
        logic [REG_AW-1:0]   rd;
        logic [DATA_W-1:0]   rs_data;
        logic [DATA_W-1:0]   rt_data;
        logic [DATA_W-1:0]   imm;
        logic [ALU_OP_W-1:0] alu_op;
        logic                alu_src;
        logic                mem_read;
        logic                mem_write;
        logic                reg_write;
        logic                mem_to_reg;
    } ex_slot_t;

    ex_slot_t         ex_q, ex_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             haz_c;
    logic             byp_rs_c, byp_rt_c;

    // Load in EX whose destination is a source the ID instruction actually reads
    always_comb begin
        haz_c = id_valid && ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                ((ex_q.rd == id_rs) || (id_uses_rt && (ex_q.rd == id_rt)));
        stall = haz_c && !flush_ex && !rst;
    end

    always_comb begin
        byp_rs_c = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs);
        byp_rt_c = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rt);
    end

    // Next EX slot: flush and hazard both produce an all-zero bubble
    always_comb begin
        ex_d = '0;
        if (!flush_ex && !haz_c) begin
            ex_d.valid   = id_valid;
            ex_d.rs      = id_rs;
            ex_d.rt      = id_rt;
            ex_d.rd      = id_rd;
            ex_d.rs_data = byp_rs_c ? wb_data : id_rs_data;
            ex_d.rt_data = byp_rt_c ? wb_data : id_rt_data;
            ex_d.imm     = id_imm;
            ex_d.alu_op  = id_alu_op;
            if (id_valid) begin
                ex_d.alu_src    = id_alu_src;
                ex_d.mem_read   = id_mem_read;
                ex_d.mem_write  = id_mem_write;
                ex_d.reg_write  = id_reg_write;
                ex_d.mem_to_reg = id_mem_to_reg;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_ex && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_rd         = ex_q.rd;
    assign ex_rs_data    = ex_q.rs_data;
    assign ex_rt_data    = ex_q.rt_data;
    assign ex_imm        = ex_q.imm;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign stall_count   = stall_cnt_q;
    assign flush_count   = flush_cnt_q;

endmodule
